// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID-side inputs, flush request, and the
// registered EX-side outputs plus stall enables and statistics.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [5:0]        id_opcode;
    logic [10:0]       id_ctrl;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic              ex_flush;
    logic [10:0]       ex_ctrl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic              pc_write;
    logic              ifid_write;
    logic              illegal_op;
    logic [15:0]       bubble_cnt;
    logic [15:0]       flush_cnt;

    modport master (
        output id_opcode, id_ctrl, id_rs, id_rt, id_rd,
        output id_rdata1, id_rdata2, id_imm, id_pc4, ex_flush,
        input  ex_ctrl, ex_rs, ex_rt, ex_rd,
        input  ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
        input  pc_write, ifid_write, illegal_op, bubble_cnt, flush_cnt
    );

    modport slave (
        input  id_opcode, id_ctrl, id_rs, id_rt, id_rd,
        input  id_rdata1, id_rdata2, id_imm, id_pc4, ex_flush,
        output ex_ctrl, ex_rs, ex_rt, ex_rd,
        output ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
        output pc_write, ifid_write, illegal_op, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core. Detects load-use
// hazards, inserts bubbles for hazards/flushes/illegal opcodes and drives
// the PC and IF/ID stall enables. Optional statistics counters are built
// when ID_EX_HAZARD_STATS_EN is defined; otherwise the counter ports read 0.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    // Control word bit position of mem_read in {reg_dst,alu_src,mem_to_reg,
    // reg_write,mem_read,mem_write,branch,jump,alu_op[1:0],zero_extnd}.
    localparam int MEM_READ_BIT = 6;

    logic [10:0]       ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
    logic [DATA_W-1:0] ex_rdata1_q, ex_rdata2_q, ex_imm_q, ex_pc4_q;
    logic              illegal_op_q, illegal_op_d;
    logic              legal;
    logic              uses_rt;
    logic              hazard;

    // Opcode classification: implemented opcodes and which read rt.
    always_comb begin
        legal   = 1'b0;
        uses_rt = 1'b0;
        case (bus.id_opcode)
            6'd0:  begin legal = 1'b1; uses_rt = 1'b1; end
            6'd43: begin legal = 1'b1; uses_rt = 1'b1; end
            6'd4:  begin legal = 1'b1; uses_rt = 1'b1; end
            6'd35: legal = 1'b1;
            6'd2:  legal = 1'b1;
            6'd13: legal = 1'b1;
            default: begin legal = 1'b0; uses_rt = 1'b0; end
        endcase
    end

    // Load-use hazard against the load currently in EX; r0 never conflicts.
    always_comb begin
        hazard = ex_ctrl_q[MEM_READ_BIT] && (ex_rt_q != '0) &&
                 ((ex_rt_q == bus.id_rs) || (uses_rt && (ex_rt_q == bus.id_rt)));
    end

    // Next control word and sticky illegal flag; flush beats hazard beats illegal.
    always_comb begin
        ex_ctrl_d    = '0;
        illegal_op_d = illegal_op_q;
        if (bus.ex_flush) begin
            ex_ctrl_d = '0;
        end else if (hazard) begin
            ex_ctrl_d = '0;
        end else if (!legal) begin
            ex_ctrl_d    = '0;
            illegal_op_d = 1'b1;
        end else begin
            ex_ctrl_d = bus.id_ctrl;
        end
    end

    // Pipeline register; data fields load every cycle regardless of bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q    <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_rdata1_q  <= '0;
            ex_rdata2_q  <= '0;
            ex_imm_q     <= '0;
            ex_pc4_q     <= '0;
            illegal_op_q <= 1'b0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_q      <= bus.id_rs;
            ex_rt_q      <= bus.id_rt;
            ex_rd_q      <= bus.id_rd;
            ex_rdata1_q  <= bus.id_rdata1;
            ex_rdata2_q  <= bus.id_rdata2;
            ex_imm_q     <= bus.id_imm;
            ex_pc4_q     <= bus.id_pc4;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_rs      = ex_rs_q;
    assign bus.ex_rt      = ex_rt_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_rdata1  = ex_rdata1_q;
    assign bus.ex_rdata2  = ex_rdata2_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_pc4     = ex_pc4_q;
    assign bus.illegal_op = illegal_op_q;

    // A flush cancels the stall so the fetch redirect is not held off.
    assign bus.pc_write   = ~(hazard & ~bus.ex_flush);
    assign bus.ifid_write = ~(hazard & ~bus.ex_flush);

`ifdef ID_EX_HAZARD_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        bubble_ins;

    // Saturating statistics: hazard/illegal bubbles and flush cycles.
    always_comb begin
        bubble_ins   = ~bus.ex_flush & (hazard | ~legal);
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_ins && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if (bus.ex_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
`else
    assign bus.bubble_cnt = '0;
    assign bus.flush_cnt  = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: each step drives one ID instruction,
// checks the combinational stall enables, pushes the expected EX state to a
// scoreboard queue and pops/compares it after the clock edge.
module tb_id_ex_stage;
    localparam logic [10:0] R_CTRL   = 11'b10010000100;
    localparam logic [10:0] LW_CTRL  = 11'b01111000000;
    localparam logic [10:0] ORI_CTRL = 11'b01010000111;

    typedef struct {
        string       tag;
        logic [10:0] ctrl;
        logic [4:0]  rt;
        logic [31:0] rdata1;
        logic [31:0] pc4;
        logic        illegal;
        logic [15:0] bcnt;
        logic [15:0] fcnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID instruction, check the stall enables before the edge,
    // then compare the EX register against the scoreboard after the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [10:0] ctrl,
                        input logic [4:0] rs, input logic [4:0] rt, input logic flush,
                        input logic exp_pw, input logic [10:0] exp_ctrl,
                        input logic exp_ill, input logic [15:0] exp_b, input logic [15:0] exp_f);
        exp_t e;
        exp_t got;
        @(negedge clk);
        bus.id_opcode = op;
        bus.id_ctrl   = ctrl;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_rd     = 5'd3;
        bus.id_rdata1 = $urandom;
        bus.id_rdata2 = $urandom;
        bus.id_imm    = $urandom;
        bus.id_pc4    = $urandom;
        bus.ex_flush  = flush;
        #1;
        chk({tag, ".pc_write"}, 64'(bus.pc_write), 64'(exp_pw));
        chk({tag, ".ifid_write"}, 64'(bus.ifid_write), 64'(exp_pw));
        e.tag     = tag;
        e.ctrl    = exp_ctrl;
        e.rt      = rt;
        e.rdata1  = bus.id_rdata1;
        e.pc4     = bus.id_pc4;
        e.illegal = exp_ill;
`ifdef ID_EX_HAZARD_STATS_EN
        e.bcnt    = exp_b;
        e.fcnt    = exp_f;
`else
        e.bcnt    = '0;
        e.fcnt    = '0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk({got.tag, ".ex_ctrl"}, 64'(bus.ex_ctrl), 64'(got.ctrl));
            chk({got.tag, ".ex_rt"}, 64'(bus.ex_rt), 64'(got.rt));
            chk({got.tag, ".ex_rdata1"}, 64'(bus.ex_rdata1), 64'(got.rdata1));
            chk({got.tag, ".ex_pc4"}, 64'(bus.ex_pc4), 64'(got.pc4));
            chk({got.tag, ".illegal_op"}, 64'(bus.illegal_op), 64'(got.illegal));
            chk({got.tag, ".bubble_cnt"}, 64'(bus.bubble_cnt), 64'(got.bcnt));
            chk({got.tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(got.fcnt));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.id_opcode = '0;
        bus.id_ctrl   = '0;
        bus.id_rs     = '0;
        bus.id_rt     = '0;
        bus.id_rd     = '0;
        bus.id_rdata1 = '0;
        bus.id_rdata2 = '0;
        bus.id_imm    = '0;
        bus.id_pc4    = '0;
        bus.ex_flush  = 1'b0;
        #12;
        chk("reset.ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
        chk("reset.ex_rdata1", 64'(bus.ex_rdata1), 64'd0);
        chk("reset.pc_write", 64'(bus.pc_write), 64'd1);
        chk("reset.illegal_op", 64'(bus.illegal_op), 64'd0);
        chk("reset.bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
        rst_n = 1'b1;

        //    tag          op     ctrl      rs     rt     fl    pw    exp ctrl  ill   b      f
        step("r_normal",   6'd0,  R_CTRL,   5'd1,  5'd2,  1'b0, 1'b1, R_CTRL,   1'b0, 16'd0, 16'd0);
        step("lw_a",       6'd35, LW_CTRL,  5'd1,  5'd8,  1'b0, 1'b1, LW_CTRL,  1'b0, 16'd0, 16'd0);
        step("load_use",   6'd0,  R_CTRL,   5'd5,  5'd8,  1'b0, 1'b0, 11'd0,    1'b0, 16'd1, 16'd0);
        step("r_replay",   6'd0,  R_CTRL,   5'd5,  5'd8,  1'b0, 1'b1, R_CTRL,   1'b0, 16'd1, 16'd0);
        step("lw_b",       6'd35, LW_CTRL,  5'd1,  5'd8,  1'b0, 1'b1, LW_CTRL,  1'b0, 16'd1, 16'd0);
        step("ori_no_rt",  6'd13, ORI_CTRL, 5'd9,  5'd8,  1'b0, 1'b1, ORI_CTRL, 1'b0, 16'd1, 16'd0);
        step("lw_r0",      6'd35, LW_CTRL,  5'd1,  5'd0,  1'b0, 1'b1, LW_CTRL,  1'b0, 16'd1, 16'd0);
        step("r0_no_haz",  6'd0,  R_CTRL,   5'd0,  5'd0,  1'b0, 1'b1, R_CTRL,   1'b0, 16'd1, 16'd0);
        step("lw_c",       6'd35, LW_CTRL,  5'd1,  5'd8,  1'b0, 1'b1, LW_CTRL,  1'b0, 16'd1, 16'd0);
        step("flush_haz",  6'd0,  R_CTRL,   5'd8,  5'd2,  1'b1, 1'b1, 11'd0,    1'b0, 16'd1, 16'd1);
        step("ill_flush",  6'd63, 11'bx,    5'd1,  5'd2,  1'b1, 1'b1, 11'd0,    1'b0, 16'd1, 16'd2);
        step("ill_x",      6'd63, 11'bx,    5'd1,  5'd2,  1'b0, 1'b1, 11'd0,    1'b1, 16'd2, 16'd2);
        for (int i = 0; i < 10; i++) begin
            step("ill_sticky", 6'd2, 11'b00000001000, 5'd0, 5'd0, 1'b0, 1'b1,
                 11'b00000001000, 1'b1, 16'd2, 16'd2);
        end
        step("pre_reset",  6'd0,  R_CTRL,   5'd1,  5'd2,  1'b0, 1'b1, R_CTRL,   1'b1, 16'd2, 16'd2);

        // Asynchronous reset in the middle of a cycle, checked before the next edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset.ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
        chk("mid_reset.ex_rdata1", 64'(bus.ex_rdata1), 64'd0);
        chk("mid_reset.ex_pc4", 64'(bus.ex_pc4), 64'd0);
        chk("mid_reset.pc_write", 64'(bus.pc_write), 64'd1);
        chk("mid_reset.illegal_op", 64'(bus.illegal_op), 64'd0);
        chk("mid_reset.bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
        chk("mid_reset.flush_cnt", 64'(bus.flush_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 6'd43, 11'b01000100000, 5'd1, 5'd2, 1'b0, 1'b1,
             11'b01000100000, 1'b0, 16'd0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the 5-stage MIPS core. It sits directly downstream of the single-cycle-style decoder and registers the decoder's control word plus operands into EX. It inserts bubbles for load-use hazards, branch/jump flushes and unimplemented opcodes. It also generates the stall enables for the PC and IF/ID registers.

Parameters:
DATA_W, 32, width of operands, immediate and PC+4
REG_AW, 5, register-specifier width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_opcode  in  6  opcode of the instruction in ID
id_ctrl  in  11  decoder control word {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump,alu_op[1:0],zero_extnd}
id_rs, id_rt, id_rd  in  REG_AW each  register specifiers
id_rdata1, id_rdata2  in  DATA_W each  register file read data
id_imm  in  DATA_W  extended immediate
id_pc4  in  DATA_W  PC+4 of the ID instruction
ex_flush  in  1  taken branch/jump resolved, kill the ID instruction
ex_ctrl  out  11  registered control word, same packing as id_ctrl
ex_rs, ex_rt, ex_rd  out  REG_AW each  registered specifiers
ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W each  registered data
pc_write  out  1  PC load enable (0 = stall)
ifid_write  out  1  IF/ID load enable (0 = stall)
illegal_op  out  1  sticky, unimplemented opcode reached ID
bubble_cnt  out  16  bubble statistics (optional feature)
flush_cnt  out  16  flush statistics (optional feature)

Behaviour:
- Reset (async, rst_n=0): all registered outputs = 0, illegal_op = 0, counters = 0. Because ex_ctrl = 0, pc_write = ifid_write = 1. Reset mid-operation discards the in-flight instruction immediately.
- Legal opcodes: 0 (R), 35 (LW), 43 (SW), 4 (BEQ), 2 (J), 13 (ORI). uses_rt = opcode in {0, 43, 4}.
- Hazard (combinational) = ex_ctrl.mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- pc_write = ifid_write = ~(hazard & ~ex_flush).
- Per-edge priority for the registered update:
  1. ex_flush: ex_ctrl <= 0.
  2. hazard: ex_ctrl <= 0 (bubble). ID holds, so the same instruction re-presents next cycle.
  3. illegal opcode: ex_ctrl <= 0 and illegal_op <= 1. id_ctrl is ignored entirely, so an X control word never enters EX.
  4. otherwise: ex_ctrl <= id_ctrl.
- Data/specifier registers load the ID values every cycle regardless of priority; their contents are don't-care under a zero control word.
- Latency is 1 cycle ID->EX.
- A bubble clears mem_read, so a hazard stall lasts at most 1 cycle.
- illegal_op stays set until reset. It is not set when the illegal opcode arrives together with ex_flush or hazard; it sets when that instruction later advances.
- Simultaneous flush and hazard: flush wins and no stall is issued, so the fetch redirect proceeds.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- Defined: bubble_cnt increments on every cycle a bubble is inserted by hazard or illegal opcode. flush_cnt increments on every ex_flush cycle. Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Reset with rst_n=0 mid-stream -> ex_ctrl=0, all ex_* outputs 0, pc_write=1, illegal_op=0 asynchronously, before the next edge.
- Normal flow: R-format opcode 0, id_ctrl=11'b10010000100 -> ex_ctrl equals it after 1 edge, and pc_write stays 1.
- Load-use: LW with ex_rt=8, next ID is R-format with id_rt=8 -> pc_write=ifid_write=0 for 1 cycle, ex_ctrl=0; then the R instruction enters EX; bubble_cnt=1 with macro defined.
- No false stall: LW with ex_rt=8, next ID is ORI with id_rt=8 and id_rs=9 -> no stall. Also ex_rt=0 with id_rs=0 -> no stall.
- Flush with hazard in the same cycle -> ex_ctrl=0 and pc_write=1; flush_cnt=1 with macro defined.
- Opcode 6'd63 with id_ctrl all X -> ex_ctrl=0 (no X), illegal_op=1 and remains 1 over 10 further cycles until rst_n pulses low.
